// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB slave port (the AHB2APB bridge) among
// NUM_MASTERS masters, with address/data-phase muxing and bounded hold time.
module ahb_master_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int WIDTH       = 32,
    parameter int MAX_HOLD    = 16,
    localparam int MW         = $clog2(NUM_MASTERS)
) (
    input  logic                         Hclk,
    input  logic                         Hreset,
    input  logic [NUM_MASTERS-1:0]       Hbusreq,
    input  logic [2*NUM_MASTERS-1:0]     m_Htrans,
    input  logic [WIDTH*NUM_MASTERS-1:0] m_Haddr,
    input  logic [NUM_MASTERS-1:0]       m_Hwrite,
    input  logic [3*NUM_MASTERS-1:0]     m_Hsize,
    input  logic [WIDTH*NUM_MASTERS-1:0] m_Hwdata,
    output logic [NUM_MASTERS-1:0]       Hgrant,
    output logic [MW-1:0]                Hmaster,
    output logic [1:0]                   Htrans,
    output logic [WIDTH-1:0]             Haddr,
    output logic                         Hwrite,
    output logic [2:0]                   Hsize,
    output logic [WIDTH-1:0]             Hwdata,
    output logic                         Hreadyin,
    input  logic                         Hreadyout,
    input  logic [1:0]                   Hresp,
    output logic                         m_Hready,
    output logic [1:0]                   m_Hresp
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [1:0] TRANS_IDLE = 2'b00;

    typedef enum logic {NOGRANT, OWNED} state_t;

    state_t                 r_state, w_state_next;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_next;
    logic [MW-1:0]          r_master, w_master_next;
    logic [MW-1:0]          r_last_ptr, w_last_ptr_next;
    logic [HW-1:0]          r_hold_cnt, w_hold_cnt_next;
    logic [MW-1:0]          r_dphase_owner;
    logic                   r_dphase_valid;

    logic [1:0]       w_trans_arr [NUM_MASTERS];
    logic [WIDTH-1:0] w_addr_arr  [NUM_MASTERS];
    logic [WIDTH-1:0] w_wdata_arr [NUM_MASTERS];
    logic [2:0]       w_size_arr  [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign w_trans_arr[gi] = m_Htrans[2*gi +: 2];
        assign w_addr_arr[gi]  = m_Haddr[WIDTH*gi +: WIDTH];
        assign w_wdata_arr[gi] = m_Hwdata[WIDTH*gi +: WIDTH];
        assign w_size_arr[gi]  = m_Hsize[3*gi +: 3];
    end

    // Round-robin search: descending loop so the nearest requester after last_ptr wins.
    logic          w_rr_found;
    logic [MW-1:0] w_rr_winner;
    logic [MW-1:0] w_rr_idx;
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        w_rr_idx    = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_rr_idx = MW'((int'(r_last_ptr) + k) % NUM_MASTERS);
            if (Hbusreq[w_rr_idx]) begin
                w_rr_found  = 1'b1;
                w_rr_winner = w_rr_idx;
            end
        end
    end

    logic       w_owner_valid;
    logic       w_owner_req;
    logic       w_other_req;
    logic [1:0] w_owner_trans;
    logic       w_preempt;

    assign w_owner_valid = (r_state == OWNED);
    assign w_owner_req   = Hbusreq[r_master];
    assign w_other_req   = |(Hbusreq & ~r_grant);
    assign w_owner_trans = w_trans_arr[r_master];
    // Only IDLE/NONSEQ (bit 0 clear) are safe pre-emption points; bursts stay intact.
    assign w_preempt     = (r_hold_cnt >= HW'(MAX_HOLD - 1)) && w_other_req && !w_owner_trans[0];

    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_master_next   = r_master;
        w_last_ptr_next = r_last_ptr;
        w_hold_cnt_next = r_hold_cnt;
        if (Hreadyout) begin
            case (r_state)
                NOGRANT: begin
                    if (w_rr_found) begin
                        w_state_next    = OWNED;
                        w_grant_next    = NUM_MASTERS'(1) << w_rr_winner;
                        w_master_next   = w_rr_winner;
                        w_last_ptr_next = w_rr_winner;
                        w_hold_cnt_next = '0;
                    end
                end
                OWNED: begin
                    if (!w_owner_req || w_preempt) begin
                        if (w_rr_found) begin
                            w_grant_next    = NUM_MASTERS'(1) << w_rr_winner;
                            w_master_next   = w_rr_winner;
                            w_last_ptr_next = w_rr_winner;
                            w_hold_cnt_next = '0;
                        end else begin
                            w_state_next = NOGRANT;
                            w_grant_next = '0;
                        end
                    end else if (r_hold_cnt < HW'(MAX_HOLD - 1)) begin
                        w_hold_cnt_next = r_hold_cnt + 1'b1;
                    end
                end
                default: w_state_next = NOGRANT;
            endcase
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state        <= NOGRANT;
            r_grant        <= '0;
            r_master       <= '0;
            r_last_ptr     <= MW'(NUM_MASTERS - 1);
            r_hold_cnt     <= '0;
            r_dphase_owner <= '0;
            r_dphase_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_master   <= w_master_next;
            r_last_ptr <= w_last_ptr_next;
            r_hold_cnt <= w_hold_cnt_next;
            if (Hreadyout) begin
                r_dphase_owner <= r_master;
                r_dphase_valid <= w_owner_valid && Htrans[1];
            end
        end
    end

    always_comb begin
        Htrans = TRANS_IDLE;
        Haddr  = '0;
        Hwrite = 1'b0;
        Hsize  = '0;
        if (w_owner_valid) begin
            Htrans = w_owner_trans;
            Haddr  = w_addr_arr[r_master];
            Hwrite = m_Hwrite[r_master];
            Hsize  = w_size_arr[r_master];
        end
    end

    // Write data follows the data-phase owner, which lags the address-phase owner by one beat.
    assign Hwdata   = r_dphase_valid ? w_wdata_arr[r_dphase_owner] : '0;
    assign Hgrant   = r_grant;
    assign Hmaster  = r_master;
    assign Hreadyin = Hreadyout;
    assign m_Hready = Hreadyout;
    assign m_Hresp  = Hresp;
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Scoreboard bench: an ownership-level model predicts each cycle's bridge-side
// outputs; a negedge monitor pops and compares them against the arbiter.
module tb_ahb_master_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MH = 16;
    localparam int MW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     busreq;
    logic [2*N-1:0]   mtrans;
    logic [W*N-1:0]   maddr, mwdata;
    logic [N-1:0]     mwrite;
    logic [3*N-1:0]   msize;
    logic             hready;
    logic [1:0]       hresp;

    logic [N-1:0]     grant;
    logic [MW-1:0]    hmaster;
    logic [1:0]       htrans;
    logic [W-1:0]     haddr, hwdata;
    logic             hwrite, hreadyin, m_hready;
    logic [2:0]       hsize;
    logic [1:0]       m_hresp;

    ahb_master_arbiter #(.NUM_MASTERS(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .Hclk(clk), .Hreset(rst), .Hbusreq(busreq), .m_Htrans(mtrans),
        .m_Haddr(maddr), .m_Hwrite(mwrite), .m_Hsize(msize), .m_Hwdata(mwdata),
        .Hgrant(grant), .Hmaster(hmaster), .Htrans(htrans), .Haddr(haddr),
        .Hwrite(hwrite), .Hsize(hsize), .Hwdata(hwdata), .Hreadyin(hreadyin),
        .Hreadyout(hready), .Hresp(hresp), .m_Hready(m_hready), .m_Hresp(m_hresp)
    );

    typedef struct {
        int           cyc;
        int           owner;
        logic [N-1:0] grant;
        logic [1:0]   trans;
        logic [W-1:0] addr;
        logic         wr;
        logic [2:0]   size;
        logic [W-1:0] wdata;
        logic         rdy;
        logic [1:0]   resp;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model: who owns the bus, how long, and whose data phase is pending.
    int own, last, held, downer, npreempt;
    bit dvalid;

    function automatic int rr_pick(input int from);
        for (int k = 1; k <= N; k++) begin
            int j = (from + k) % N;
            if (busreq[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step();
        int  prev;
        bit  others, preempt;
        prev = own;
        if (rst) begin
            own = -1; last = N - 1; held = 0; dvalid = 0; downer = 0;
        end else if (hready) begin
            dvalid = 0;
            if (own >= 0) begin
                dvalid = mtrans[2*own+1];
                downer = own;
            end
            if (own < 0) begin
                own = rr_pick(last);
                if (own >= 0) begin last = own; held = 0; end
            end else begin
                others = 0;
                for (int j = 0; j < N; j++) if (j != own && busreq[j]) others = 1;
                preempt = (held >= MH - 1) && others && (mtrans[2*own] == 1'b0);
                if (!busreq[own] || preempt) begin
                    if (preempt && busreq[own]) npreempt++;
                    own = rr_pick(own);
                    if (own >= 0) begin last = own; held = 0; end
                end else if (held < MH - 1) begin
                    held++;
                end
            end
        end
        if (own != prev && own >= 0) $display("txn cyc=%0d grant -> m%0d", cyc, own);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic push();
        exp_t x;
        x.cyc   = cyc;
        x.owner = own;
        x.grant = '0; x.trans = 2'b00; x.addr = '0; x.wr = 1'b0; x.size = 3'b000;
        if (own >= 0) begin
            x.grant = N'(1) << own;
            x.trans = mtrans[2*own +: 2];
            x.addr  = maddr[W*own +: W];
            x.wr    = mwrite[own];
            x.size  = msize[3*own +: 3];
        end
        x.wdata = dvalid ? mwdata[W*downer +: W] : '0;
        x.rdy   = hready;
        x.resp  = hresp;
        sbq.push_back(x);
    endtask

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, c, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("hgrant",   e.cyc, 64'(grant),    64'(e.grant));
            chk("htrans",   e.cyc, 64'(htrans),   64'(e.trans));
            chk("haddr",    e.cyc, 64'(haddr),    64'(e.addr));
            chk("hwrite",   e.cyc, 64'(hwrite),   64'(e.wr));
            chk("hsize",    e.cyc, 64'(hsize),    64'(e.size));
            chk("hwdata",   e.cyc, 64'(hwdata),   64'(e.wdata));
            chk("hreadyin", e.cyc, 64'(hreadyin), 64'(e.rdy));
            chk("m_hready", e.cyc, 64'(m_hready), 64'(e.rdy));
            chk("m_hresp",  e.cyc, 64'(m_hresp),  64'(e.resp));
            if (e.owner >= 0) chk("hmaster", e.cyc, 64'(hmaster), 64'(e.owner));
        end
    end

    task automatic set_idle();
        busreq = '0; mtrans = '0; maddr = '0; mwdata = '0; mwrite = '0; msize = '0;
    endtask

    initial begin
        logic [N-1:0] done;
        own = -1; last = N - 1; held = 0; dvalid = 0; downer = 0; npreempt = 0;
        rst = 1'b1; hready = 1'b1; hresp = 2'b00;
        set_idle();

        // Reset, then a single m0 NONSEQ write to 0x8000_0000.
        tick(); push();
        tick(); rst = 1'b0;
        busreq = 4'b0001; mtrans[1:0] = 2'b10; maddr[31:0] = 32'h8000_0000;
        mwrite[0] = 1'b1; msize[2:0] = 3'b010; mwdata[31:0] = 32'hA5A5_A5A5;
        push();
        repeat (3) begin tick(); push(); end
        tick(); set_idle(); push();
        repeat (2) begin tick(); push(); end

        // All four request; each drops its request right after being granted.
        done = '0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (own >= 0) done[own] = 1'b1;
            if (&done) done = '0;
            busreq = ~done;
            for (int i = 0; i < N; i++) begin
                mtrans[2*i +: 2] = 2'b10;
                maddr[W*i +: W]  = 32'h1000_0000 * (i + 1) + c;
                mwdata[W*i +: W] = 32'hD000_0000 + 32'h100 * i + c;
                mwrite[i] = 1'b1;
            end
            push();
        end

        // m0 streams NONSEQ singles while m3 waits: pre-emption after MAX_HOLD grants.
        for (int c = 0; c < 60; c++) begin
            tick();
            busreq = 4'b1001;
            mtrans = 8'b10_00_00_10;
            maddr[31:0]   = 32'h2000_0000 + 4 * c;
            maddr[127:96] = 32'h3000_0000 + 4 * c;
            mwdata[31:0]  = $urandom;
            mwdata[127:96] = $urandom;
            push();
        end

        // Randomised traffic: sticky requests, wait states, errors, occasional reset.
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) busreq[i] = ~busreq[i];
                mtrans[2*i +: 2] = 2'($urandom_range(0, 3));
                maddr[W*i +: W]  = $urandom;
                mwdata[W*i +: W] = $urandom;
                mwrite[i]        = 1'($urandom_range(0, 1));
                msize[3*i +: 3]  = 3'($urandom_range(0, 2));
            end
            hready = ($urandom_range(0, 4) != 0);
            hresp  = ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b00;
            rst    = ($urandom_range(0, 299) == 0);
            push();
        end

        tick();
        @(negedge clk);
        #1;
        chk("sb_drain", cyc, 64'(sbq.size()), 64'd0);
        $display("info: model pre-emptions=%0d", npreempt);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
